// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared constants and types for the memory port arbiter
//
// Purpose: word/memory geometry, default requester count, FSM state encoding,
// flag addresses used by the learning sub-blocks, and a small index helper.
// Ports: none (package).
package mem_port_arbiter_pkg;

  localparam int ARB_WORD_WIDTH      = 16;
  localparam int ARB_MEM_DEPTH       = 1 << ARB_WORD_WIDTH;
  localparam int ARB_DEFAULT_NREQ    = 4;
  localparam int ARB_DEFAULT_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN   = 2'd1,
    ARB_PURGE = 2'd2
  } arb_state_t;

  // Flag words the clients poll/set in node memory.
  localparam logic [ARB_WORD_WIDTH-1:0] FLAG_ACTION_DONE  = 16'h0000;
  localparam logic [ARB_WORD_WIDTH-1:0] FLAG_QUPDATE_DONE = 16'h0001;
  localparam logic [ARB_WORD_WIDTH-1:0] FLAG_PKT_READY    = 16'h0002;

  // Successor of a requester index, wrapping n-1 back to 0.
  function automatic logic [2:0] next_index(input logic [2:0] idx, input int n);
    return (int'(idx) == n - 1) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rtl/mem_port_arbiter_rr_pick.sv - combinational round-robin pick
//
// Purpose: select the first asserted request at or after ptr, wrapping.
// Ports:
//   req      in   NREQ  request vector
//   ptr      in   3     round-robin start index
//   pick     out  NREQ  one-hot selection (0 when nothing requested)
//   pick_idx out  3     index of the selected requester
//   valid    out  1     at least one request present
module mem_port_arbiter_rr_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int NREQ = ARB_DEFAULT_NREQ
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [NREQ-1:0] pick,
  output logic [2:0]      pick_idx,
  output logic            valid
);

  // Doubling the vector lets a plain shift stand in for the rotation.
  logic [2*NREQ-1:0] dbl;
  assign dbl = {req, req} >> ptr;

  always_comb begin
    int sum;
    sum      = 0;
    valid    = 1'b0;
    pick_idx = '0;
    for (int off = 0; off < NREQ; off++) begin
      if (!valid && dbl[off]) begin
        valid = 1'b1;
        sum   = int'(ptr) + off;
        if (sum >= NREQ) sum = sum - NREQ;
        pick_idx = 3'(sum);
      end
    end
  end

  always_comb begin
    pick = '0;
    for (int i = 0; i < NREQ; i++) begin
      pick[i] = valid && (pick_idx == 3'(i));
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin owner arbiter for the node's single memory port
//
// Purpose: grants exclusive use of the memory port to one learning sub-block at a
// time and muxes the owner's address/data/write enable onto the port.
// Optional feature: MEM_ARB_TIMEOUT_EN bounds ownership to TIMEOUT cycles.
// Ports:
//   clock, nrst                   clock, asynchronous active-low reset
//   req/req_wr_en                 per-requester request and write enable
//   req_address/req_data_out      flattened per-requester address/write data
//   gnt/owner/busy                one-hot grant, owner index, port owned
//   mem_address/mem_wr_en/
//   mem_data_out/mem_data_in      memory side
//   data_in                       read data broadcast to requesters
//   timeout                       one-cycle pulse on forced revocation
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NREQ       = ARB_DEFAULT_NREQ,
  parameter int WORD_WIDTH = ARB_WORD_WIDTH,
  parameter int TIMEOUT    = ARB_DEFAULT_TIMEOUT
) (
  input  logic                       clock,
  input  logic                       nrst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            req_wr_en,
  input  logic [NREQ*WORD_WIDTH-1:0] req_address,
  input  logic [NREQ*WORD_WIDTH-1:0] req_data_out,
  output logic [NREQ-1:0]            gnt,
  output logic [2:0]                 owner,
  output logic                       busy,
  output logic [WORD_WIDTH-1:0]      mem_address,
  output logic                       mem_wr_en,
  output logic [WORD_WIDTH-1:0]      mem_data_out,
  input  logic [WORD_WIDTH-1:0]      mem_data_in,
  output logic [WORD_WIDTH-1:0]      data_in,
  output logic                       timeout
);

  arb_state_t      state;
  logic [NREQ-1:0] own_mask;  // one-hot of owner; outlives gnt through PURGE
  logic [2:0]      ptr;
  logic [NREQ-1:0] pick;
  logic [2:0]      pick_idx;
  logic            pick_valid;
  logic            owner_req;

  assign owner_req = |(req & own_mask);

  // Only IDLE consults the pick, so PURGE blocks every requester implicitly.
  mem_port_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
    .req      (req),
    .ptr      (ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .valid    (pick_valid)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] own_cnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT != 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state    <= ARB_IDLE;
      gnt      <= '0;
      own_mask <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      ptr      <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      timeout  <= 1'b0;
      own_cnt  <= '0;
`endif
    end else begin
`ifdef MEM_ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            gnt      <= pick;
            own_mask <= pick;
            owner    <= pick_idx;
            busy     <= 1'b1;
            state    <= ARB_OWN;
`ifdef MEM_ARB_TIMEOUT_EN
            own_cnt  <= '0;
`endif
          end
        end
        ARB_OWN: begin
          if (!owner_req) begin
            gnt      <= '0;
            own_mask <= '0;
            busy     <= 1'b0;
            ptr      <= next_index(owner, NREQ);
            state    <= ARB_IDLE;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (own_cnt == CW'(TIMEOUT - 1)) begin
            // Revoke but keep own_mask so PURGE can wait for this requester to let go.
            gnt     <= '0;
            busy    <= 1'b0;
            timeout <= 1'b1;
            ptr     <= next_index(owner, NREQ);
            state   <= ARB_PURGE;
          end else begin
            own_cnt <= own_cnt + 1'b1;
          end
`endif
        end
        ARB_PURGE: begin
          if (!owner_req) begin
            own_mask <= '0;
            state    <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Port mux: nothing reaches memory unless the requester is the registered owner.
  always_comb begin
    mem_address  = '0;
    mem_data_out = '0;
    mem_wr_en    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (busy && owner == 3'(i)) begin
        mem_address  = req_address[i*WORD_WIDTH +: WORD_WIDTH];
        mem_data_out = req_data_out[i*WORD_WIDTH +: WORD_WIDTH];
        mem_wr_en    = gnt[i] & req_wr_en[i];
      end
    end
  end

  assign data_in = mem_data_in;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares the node's single 16-bit memory port (address, write enable, write data, read data) among the node's learning sub-blocks (action selection, Q-update, packet handling). A requester raises its request, is granted exclusive ownership of the port, drives address/data/wr_en while it holds its request, and releases by dropping the request. Sits between the sub-blocks and the node memory; the memory itself is unchanged.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8).
- WORD_WIDTH, 16: address and data width.
- TIMEOUT, 64: maximum ownership cycles (used only with MEM_ARB_TIMEOUT_EN).

Ports:
- clock  in  1  single clock, rising edge.
- nrst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request, level; held for the whole access.
- req_wr_en  in  NREQ  per-requester write enable.
- req_address  in  NREQ*WORD_WIDTH  flattened addresses; requester i at [i*W +: W].
- req_data_out  in  NREQ*WORD_WIDTH  flattened write data.
- gnt  out  NREQ  one-hot grant, registered.
- owner  out  3  index of current owner (valid when busy).
- busy  out  1  port owned.
- mem_address  out  WORD_WIDTH  to memory.
- mem_wr_en  out  1  to memory.
- mem_data_out  out  WORD_WIDTH  write data to memory.
- mem_data_in  in  WORD_WIDTH  read data from memory.
- data_in  out  WORD_WIDTH  read data broadcast to all requesters.
- timeout  out  1  one-cycle pulse on forced revocation.

## Operation
- States: IDLE, OWN, PURGE.
- IDLE: if any eligible req, pick the first requester at or after ptr (wrapping NREQ-1 → 0); register gnt[k]=1, owner=k, busy=1, go OWN. No eligible req: stay IDLE, outputs idle.
- OWN: while req[owner]=1 stay. On req[owner]=0: gnt, busy cleared next edge, ptr ← owner+1 (mod NREQ), go IDLE.
- Port mux: mem_address/mem_data_out = owner's fields when busy, else 0; mem_wr_en = busy & gnt[owner] & req_wr_en[owner]; a requester's wr_en while not granted never reaches memory.
- data_in = mem_data_in, passed through combinationally to all.
- Requests from non-owners are ignored during OWN; they are held and served in round-robin order.
- PURGE: only with timeout feature (see Configuration).
- Reset values: gnt=0, owner=0, busy=0, ptr=0, timeout=0, state IDLE, mem_wr_en=0, mem_address=0, mem_data_out=0.
- Reset mid-ownership: grant dropped immediately (asynchronous); any write in flight is not issued.

## Timing
- Grant latency: req rising before edge N (IDLE) → gnt high after edge N.
- Release: req low before edge M → gnt low after edge M; earliest next grant after edge M+1 (one bubble cycle guaranteed between owners).
- Owner may issue a write every cycle while granted; memory sees exactly the owner's wr_en cycles.
- Simultaneous requests from all NREQ at reset: order 0,1,2,...,NREQ-1.
- Requester that drops and re-raises in the bubble cycle is eligible but sits behind all others by ptr.

## Configuration
- MEM_ARB_TIMEOUT_EN defined: ownership counter starts at grant; after TIMEOUT cycles in OWN the grant is revoked, timeout pulses one cycle, ptr ← owner+1, state PURGE; PURGE masks the revoked requester until its req drops (then IDLE), while others may not be granted until PURGE exits.
- Not defined: no counter, ownership unbounded, PURGE unreachable, timeout tied 0.

## Structure
- Shared package: WORD_WIDTH, MEM_DEPTH, default NREQ, state encoding constants, FLAG address constants used by clients.
- Sub-module rr_pick: combinational round-robin pick (req, ptr → one-hot, valid).

## Test plan
- Single req[1] with wr_en, address 16'h0002, data 16'h0001 → gnt=4'b0010 after 1 edge; memory write at 0x0002 value 0x0001; gnt clears 1 edge after req drops.
- req=4'b1111 from reset, each holds 3 cycles → grants 0,1,2,3 in order, one bubble between each.
- req[2] owning, req[0] raised → req[0] granted only after req[2] release; ptr=3 so req[3], if pending, precedes req[0].
- Non-granted requester drives wr_en=1, address 0x7FE → mem_wr_en stays 0.
- nrst low during OWN → gnt=0, busy=0, mem_wr_en=0 immediately; after release, req[3] pending is granted before req[0] fails (ptr=0 → req[0] first).
- MEM_ARB_TIMEOUT_EN, TIMEOUT=64: req[0] held 100 cycles → gnt revoked at cycle 64, timeout pulse, req[1] granted only after req[0] drops.
